// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TX FIFO, programmable baud divider, STATUS/DIVISOR/CTRL registers.
// Build option: define MMIO_UART_TX_IRQ_EN to enable CTRL[2] irq_en and the o_irq output.
module mmio_uart_tx #(
  parameter logic [29:0] BASE_ADDR       = 30'h0400_0000,
  parameter int          FIFO_DEPTH_LOG2 = 4,
  parameter logic [15:0] DIV_RESET       = 16'd867
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [29:0] i_mmio_addr,
  input  logic [31:0] i_mmio_data,
  input  logic [3:0]  i_mmio_mask,
  input  logic        i_mmio_wren,
  output logic [31:0] o_mmio_data,
  output logic        o_tx,
  output logic        o_irq
);

  localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic [7:0]                 r_mem [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] r_wr_ptr, r_rd_ptr;
  logic [FIFO_DEPTH_LOG2:0]   r_count;
  logic                       r_overflow, r_enable;
  logic [15:0]                r_divisor;

  state_t      r_state, w_state_next;
  logic [15:0] r_cnt, w_cnt_next, r_div, w_div_next;
  logic [2:0]  r_idx, w_idx_next;
  logic [7:0]  r_shift, w_shift_next;
  logic        r_tx, w_tx_next;
  logic        w_pop;

  logic        w_sel, w_wr, w_full, w_empty, w_busy, w_start_ok;
  logic        w_push_req, w_push, w_div_wr, w_ctrl_wr;
  logic        w_irq_en;
  logic [7:0]  w_level;
  logic        w_unused;

  assign w_sel      = (i_mmio_addr[29:2] == BASE_ADDR[29:2]);
  assign w_wr       = i_mmio_wren & w_sel;
  assign w_push_req = w_wr & (i_mmio_addr[1:0] == 2'd0) & i_mmio_mask[0];
  assign w_div_wr   = w_wr & (i_mmio_addr[1:0] == 2'd2);
  assign w_ctrl_wr  = w_wr & (i_mmio_addr[1:0] == 2'd3) & i_mmio_mask[0];
  // Count never exceeds DEPTH, so its MSB alone marks a full FIFO.
  assign w_full     = r_count[FIFO_DEPTH_LOG2];
  assign w_empty    = (r_count == '0);
  assign w_push     = w_push_req & ~w_full;
  assign w_busy     = (r_state != S_IDLE);
  assign w_start_ok = r_enable & ~w_empty;
  assign w_level    = 8'(r_count);
  assign w_unused   = &{1'b0, i_mmio_data[31:16], i_mmio_mask[3:2]};

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_mmio_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
      r_enable   <= 1'b1;
      r_divisor  <= DIV_RESET;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + {{FIFO_DEPTH_LOG2{1'b0}}, w_push}
                         - {{FIFO_DEPTH_LOG2{1'b0}}, w_pop};
      // A dropped push outranks a same-cycle W1C clear.
      if (w_push_req & w_full)
        r_overflow <= 1'b1;
      else if (w_ctrl_wr & i_mmio_data[1])
        r_overflow <= 1'b0;
      if (w_ctrl_wr) r_enable <= i_mmio_data[0];
      if (w_div_wr & i_mmio_mask[0]) r_divisor[7:0]  <= i_mmio_data[7:0];
      if (w_div_wr & i_mmio_mask[1]) r_divisor[15:8] <= i_mmio_data[15:8];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_div   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_div   <= w_div_next;
      r_idx   <= w_idx_next;
      r_shift <= w_shift_next;
      r_tx    <= w_tx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_div_next   = r_div;
    w_idx_next   = r_idx;
    w_shift_next = r_shift;
    w_tx_next    = r_tx;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tx_next = 1'b1;
        if (w_start_ok) begin
          w_pop        = 1'b1;
          w_shift_next = r_mem[r_rd_ptr];
          w_div_next   = r_divisor;
          w_cnt_next   = r_divisor;
          w_tx_next    = 1'b0;
          w_state_next = S_START;
        end
      end
      S_START: begin
        if (r_cnt == '0) begin
          w_cnt_next   = r_div;
          w_tx_next    = r_shift[0];
          w_shift_next = {1'b0, r_shift[7:1]};
          w_idx_next   = '0;
          w_state_next = S_DATA;
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      S_DATA: begin
        if (r_cnt == '0) begin
          w_cnt_next = r_div;
          if (r_idx == 3'd7) begin
            w_tx_next    = 1'b1;
            w_state_next = S_STOP;
          end else begin
            w_tx_next    = r_shift[0];
            w_shift_next = {1'b0, r_shift[7:1]};
            w_idx_next   = r_idx + 1'b1;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
      default: begin
        if (r_cnt == '0) begin
          // Chain straight into the next start bit when more data is queued.
          if (w_start_ok) begin
            w_pop        = 1'b1;
            w_shift_next = r_mem[r_rd_ptr];
            w_div_next   = r_divisor;
            w_cnt_next   = r_divisor;
            w_tx_next    = 1'b0;
            w_state_next = S_START;
          end else begin
            w_state_next = S_IDLE;
          end
        end else begin
          w_cnt_next = r_cnt - 1'b1;
        end
      end
    endcase
  end

`ifdef MMIO_UART_TX_IRQ_EN
  logic r_irq_en, r_irq;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_ctrl_wr) r_irq_en <= i_mmio_data[2];
      r_irq <= r_irq_en & w_empty & ~w_busy;
    end
  end

  assign w_irq_en = r_irq_en;
  assign o_irq    = r_irq;
`else
  assign w_irq_en = 1'b0;
  assign o_irq    = 1'b0;
`endif

  always_comb begin
    o_mmio_data = '0;
    if (w_sel) begin
      case (i_mmio_addr[1:0])
        2'd1:    o_mmio_data = {16'd0, w_level, 4'd0, r_overflow, w_empty, w_full, w_busy};
        2'd2:    o_mmio_data = {16'd0, r_divisor};
        2'd3:    o_mmio_data = {29'd0, w_irq_en, 1'b0, r_enable};
        default: o_mmio_data = '0;
      endcase
    end
  end

  assign o_tx = r_tx;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Bench for mmio_uart_tx: register checks from the stimulus thread, serial frames checked by a
// monitor that pops expected bytes from a scoreboard queue and rebuilds each 10-bit frame.
module tb_mmio_uart_tx;
  localparam logic [29:0] BASE = 30'h0400_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [29:0] i_mmio_addr = BASE;
  logic [31:0] i_mmio_data = '0;
  logic [3:0]  i_mmio_mask = '0;
  logic        i_mmio_wren = 1'b0;
  logic [31:0] o_mmio_data;
  logic        o_tx;
  logic        o_irq;

  mmio_uart_tx dut (
    .clk(clk), .rst(rst),
    .i_mmio_addr(i_mmio_addr), .i_mmio_data(i_mmio_data),
    .i_mmio_mask(i_mmio_mask), .i_mmio_wren(i_mmio_wren),
    .o_mmio_data(o_mmio_data), .o_tx(o_tx), .o_irq(o_irq)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0] data;
    int         div;
  } frame_t;

  frame_t      sb_q[$];
  int unsigned starts[$];
  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned last_wr_cyc;

`ifdef MMIO_UART_TX_IRQ_EN
  localparam bit IRQ_BUILD = 1'b1;
`else
  localparam bit IRQ_BUILD = 1'b0;
`endif

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, got, exp);
    end else begin
      $display("[TB] ok %s = 0x%08h", name, got);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mmio_write(input logic [1:0] off, input logic [31:0] data, input logic [3:0] mask);
    i_mmio_addr = BASE + 30'(off);
    i_mmio_data = data;
    i_mmio_mask = mask;
    i_mmio_wren = 1'b1;
    @(posedge clk);
    #1;
    i_mmio_wren = 1'b0;
    i_mmio_mask = '0;
    last_wr_cyc = cyc;
  endtask

  task automatic rd(input logic [29:0] addr, output logic [31:0] v);
    i_mmio_addr = addr;
    #1;
    v = o_mmio_data;
  endtask

  task automatic send(input logic [7:0] b, input int div);
    frame_t f;
    f.data = b;
    f.div  = div;
    sb_q.push_back(f);
    mmio_write(2'd0, {24'd0, b}, 4'b0001);
  endtask

  task automatic wait_idle(input int budget);
    logic [31:0] v;
    for (int i = 0; i < budget; i++) begin
      rd(BASE + 30'd1, v);
      if (v[2] && !v[0]) return;
      step(1);
    end
    n_tests++;
    n_fail++;
    $display("FAIL wait_idle: still busy after %0d cycles, required idle", budget);
  endtask

  // Monitor: expected line level for sample j of a frame is bit (j / (div+1)) of {stop, data, start}.
  initial begin
    bit         active = 1'b0;
    bit         rogue  = 1'b0;
    int         j = 0, bad = 0, per = 1;
    frame_t     cur;
    logic [9:0] bits;
    logic [7:0] got;
    forever begin
      @(negedge clk);
      if (rst) begin
        active = 1'b0;
        continue;
      end
      if (!active && o_tx === 1'b0) begin
        active = 1'b1;
        j = 0;
        bad = 0;
        got = '0;
        starts.push_back(cyc);
        if (sb_q.size() == 0) begin
          rogue = 1'b1;
          cur.data = 8'h00;
          cur.div = 0;
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
        end else begin
          rogue = 1'b0;
          cur = sb_q.pop_front();
        end
        per = cur.div + 1;
      end
      if (active) begin
        bits = {1'b1, cur.data, 1'b0};
        if (o_tx !== bits[j / per]) bad++;
        if ((j / per) >= 1 && (j / per) <= 8 && (j % per) == (per / 2))
          got[(j / per) - 1] = o_tx;
        j++;
        if (j == 10 * per) begin
          active = 1'b0;
          if (!rogue) begin
            n_tests++;
            if (bad != 0 || got !== cur.data) begin
              n_fail++;
              $display("FAIL frame: got byte 0x%02h with %0d off-pattern samples, required 0x%02h div %0d",
                       got, bad, cur.data, cur.div);
            end else begin
              $display("[TB] frame 0x%02h div %0d ok at cycle %0d", cur.data, cur.div, cyc);
            end
          end
        end
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int          cnt, bad, e;
    logic [7:0]  b;

    step(3);
    rst = 1'b0;

    // Reset state
    rd(BASE + 30'd0, v); check("rst_txdata", v, 32'h0);
    rd(BASE + 30'd1, v); check("rst_status", v, 32'h4);
    rd(BASE + 30'd2, v); check("rst_divisor", v, 32'h363);
    rd(BASE + 30'd3, v); check("rst_ctrl", v, 32'h1);
    rd(BASE + 30'd4, v); check("non_decoded", v, 32'h0);
    check("rst_tx", {31'd0, o_tx}, 32'h1);

    // Byte-lane masking on DIVISOR and TXDATA
    mmio_write(2'd2, 32'hFFFF_AB12, 4'b0001);
    rd(BASE + 30'd2, v); check("div_mask0", v, 32'h0312);
    mmio_write(2'd2, 32'h0000_0500, 4'b0010);
    rd(BASE + 30'd2, v); check("div_mask1", v, 32'h0512);
    mmio_write(2'd2, 32'h0000_FFFF, 4'b0000);
    rd(BASE + 30'd2, v); check("div_mask_none", v, 32'h0512);
    mmio_write(2'd0, 32'h0000_0077, 4'b1110);
    rd(BASE + 30'd1, v); check("txdata_no_lane0", v, 32'h4);

    // Single frame at DIVISOR = 3
    mmio_write(2'd2, 32'd3, 4'b0011);
    starts.delete();
    send(8'h55, 3);
    e = int'(last_wr_cyc);
    rd(BASE + 30'd1, v); check("status_after_push", v, 32'h0000_0100);
    step(1);
    cnt = 0;
    for (int i = 0; i < 200; i++) begin
      rd(BASE + 30'd1, v);
      if (!v[0]) break;
      cnt++;
      step(1);
    end
    check("busy_cycles", cnt, 32'd40);
    check("start_latency", (starts.size() > 0) ? starts[0] : 32'hFFFF_FFFF, 32'(e + 1));

    // Back-to-back frames at DIVISOR = 1
    mmio_write(2'd2, 32'd1, 4'b0011);
    starts.delete();
    send(8'hA5, 1);
    e = int'(last_wr_cyc);
    rd(BASE + 30'd1, v); check("b2b_level_a", 32'(v[15:8]), 32'd1);
    step(1);
    rd(BASE + 30'd1, v); check("b2b_level_b", 32'(v[15:8]), 32'd0);
    send(8'h3C, 1);
    rd(BASE + 30'd1, v); check("b2b_level_c", 32'(v[15:8]), 32'd1);
    step(19);
    rd(BASE + 30'd1, v); check("b2b_level_d", v, 32'h5);
    wait_idle(200);
    check("b2b_gap", (starts.size() == 2) ? (starts[1] - starts[0]) : 32'hFFFF_FFFF, 32'd20);

    // Overflow with transmitter disabled, then W1C clear and re-enable
    mmio_write(2'd3, 32'd0, 4'b0001);
    for (int i = 0; i < 17; i++) begin
      b = 8'($urandom);
      if (i < 16) send(b, 1);
      else mmio_write(2'd0, {24'd0, b}, 4'b0001);
    end
    rd(BASE + 30'd1, v); check("ovf_status", v, 32'h0000_100A);
    mmio_write(2'd3, 32'd3, 4'b0001);
    rd(BASE + 30'd1, v); check("ovf_cleared", v, 32'h0000_1002);
    rd(BASE + 30'd3, v); check("ctrl_w1c_reads0", v, 32'h1);
    wait_idle(2000);
    check("ovf_drained", sb_q.size(), 32'd0);

    // Randomized bursts, DIVISOR held constant within a burst
    for (int r = 0; r < 5; r++) begin
      cnt = int'($urandom_range(0, 4));
      mmio_write(2'd2, 32'(cnt), 4'b0011);
      for (int k = 0; k < int'($urandom_range(1, 16)); k++) begin
        send(8'($urandom), cnt);
        step(int'($urandom_range(0, 3)));
      end
      wait_idle(3000);
    end
    check("rand_drained", sb_q.size(), 32'd0);

    // Reset in the middle of DATA bit 3 (0x96 bit3 = 0)
    mmio_write(2'd2, 32'd3, 4'b0011);
    send(8'h96, 3);
    step(17);
    check("bit3_level", {31'd0, o_tx}, 32'h0);
    rst = 1'b1;
    step(1);
    check("rst_mid_tx", {31'd0, o_tx}, 32'h1);
    rst = 1'b0;
    rd(BASE + 30'd1, v); check("rst_mid_status", v, 32'h4);
    rd(BASE + 30'd2, v); check("rst_mid_divisor", v, 32'h363);
    rd(BASE + 30'd3, v); check("rst_mid_ctrl", v, 32'h1);

    // Interrupt behaviour (tied low when the option is not built)
    mmio_write(2'd2, 32'd0, 4'b0011);
    mmio_write(2'd3, 32'd5, 4'b0001);
    step(2);
    rd(BASE + 30'd3, v); check("irq_ctrl", v, IRQ_BUILD ? 32'h5 : 32'h1);
    check("irq_idle", {31'd0, o_irq}, {31'd0, IRQ_BUILD});
    send(8'hC3, 0);
    bad = 0;
    for (int k = 1; k <= 11; k++) begin
      step(1);
      if (o_irq !== 1'b0) bad++;
    end
    check("irq_low_while_busy", bad, 32'd0);
    rd(BASE + 30'd1, v); check("irq_frame_done", v, 32'h4);
    step(1);
    check("irq_after_idle", {31'd0, o_irq}, {31'd0, IRQ_BUILD});

    wait_idle(100);
    step(5);
    check("final_scoreboard_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
